display_scan_unit: RTL

Parametrised CPU output port that drives a time-multiplexed multi-digit 7-segment display. It latches an output word from the datapath and converts it to BCD with a sequential shift-add-3 engine, one bit per clock. It then scans the digits with one-hot anode drive. It sits at the end of the CPU datapath, loaded by the controller's output-load strobe. Over the fixed two-digit output port it adds configurable width and digit count, signed display, leading-zero blanking and multiplexed pins.

---
 rtl/display_pkg.sv | 55 +++++
 rtl/bin2bcd_seq.sv | 74 +++++++
 rtl/display_scan_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the 7-segment output port: active-low segment
// patterns (bit7 = dp, bits6..0 = g..a), the 4-bit digit-code enum, and the
// code-to-pattern mapping.
package display_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_ERR   = 8'h86;

  typedef enum logic [3:0] {
    DC_0     = 4'd0,
    DC_1     = 4'd1,
    DC_2     = 4'd2,
    DC_3     = 4'd3,
    DC_4     = 4'd4,
    DC_5     = 4'd5,
    DC_6     = 4'd6,
    DC_7     = 4'd7,
    DC_8     = 4'd8,
    DC_9     = 4'd9,
    DC_BLANK = 4'd10,
    DC_MINUS = 4'd11,
    DC_ERR   = 4'd12
  } digit_code_t;

  function automatic logic [7:0] seg_of(input digit_code_t c);
    case (c)
      DC_0:     return SEG_0;
      DC_1:     return SEG_1;
      DC_2:     return SEG_2;
      DC_3:     return SEG_3;
      DC_4:     return SEG_4;
      DC_5:     return SEG_5;
      DC_6:     return SEG_6;
      DC_7:     return SEG_7;
      DC_8:     return SEG_8;
      DC_9:     return SEG_9;
      DC_MINUS: return SEG_MINUS;
      DC_ERR:   return SEG_ERR;
      default:  return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock.
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts a conversion)
//   start      load bin and (re)start; wins over a conversion in progress
//   bin        unsigned value to convert (DATA_W bits)
//   busy       high from the edge after start until the result is final
//   done       combinational: high in the last busy cycle, bcd is final
//   bcd        4*DIGITS-bit packed BCD, digit 0 in bits 3..0
module bin2bcd_seq #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_p0;
  logic [BCD_W-1:0]  bcd_p0;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt;
  logic              busy_r;

  // Every nibble of 5 or more gets +3 so that the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj = add3(bcd_p0);

  // Control: bit counter and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt    <= CNT_W'(DATA_W);
    end else if (busy_r) begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      else           busy_r <= 1'b0;
    end
  end

  // Datapath: binary shifter feeding the BCD accumulator MSB first.
  always_ff @(posedge clk) begin
    if (start) begin
      shift_p0 <= bin;
      bcd_p0   <= '0;
    end else if (busy_r && cnt != '0) begin
      shift_p0 <= {shift_p0[DATA_W-2:0], 1'b0};
      bcd_p0   <= {bcd_adj[BCD_W-2:0], shift_p0[DATA_W-1]};
    end
  end

  assign busy = busy_r;
  assign done = busy_r && (cnt == '0);
  assign bcd  = bcd_p0;

endmodule

// File: rtl/display_scan_unit.sv
// display_scan_unit
// CPU output port driving a time-multiplexed 7-segment display. A load (lo)
// or clear (clr) latches a word and starts a BCD conversion; the finished
// digits, sign and overflow are committed to display registers, which a
// free-running scanner shows one digit at a time.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        latch zero and convert (priority over lo)
//   lo         latch data and convert
//   data       DATA_W-bit output word
//   busy       conversion in progress
//   an         active-low one-hot anode enables, digit 0 = an[0]
//   seg        active-low segments, bit7 = dp (always off), bits6..0 = g..a
module display_scan_unit #(
  parameter int DATA_W   = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1024,
  parameter int SIGNED   = 0,
  parameter int LZ_BLANK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              lo,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg
);

  import display_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [31:0] MAX_POS = 32'(10 ** DIGITS - 1);
  localparam logic [31:0] MAX_NEG = 32'(10 ** (DIGITS - 1) - 1);

  function automatic logic is_neg(input logic [DATA_W-1:0] w);
    return (SIGNED != 0) && w[DATA_W-1];
  endfunction

  // Unsigned DATA_W-bit magnitude; the most negative word maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] w);
    return is_neg(w) ? (~w + DATA_W'(1)) : w;
  endfunction

  // A minus sign costs the top digit, so negatives have one digit less room.
  function automatic logic overflow(input logic [DATA_W-1:0] w);
    logic [31:0] m;
    m = 32'(magnitude(w));
    return is_neg(w) ? (m > MAX_NEG) : (m > MAX_POS);
  endfunction

  logic              load;
  logic [DATA_W-1:0] word_in;
  logic [DATA_W-1:0] mag_in;
  logic [DATA_W-1:0] latch_p0;
  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic              commit;
  logic [BCD_W-1:0]  disp_bcd;
  logic              disp_neg;
  logic              disp_ovf;
  digit_code_t       codes [DIGITS];
  logic [PRE_W-1:0]  pre;
  logic [IDX_W-1:0]  idx;

  assign load    = lo | clr;
  assign word_in = clr ? '0 : data;
  assign mag_in  = magnitude(word_in);

  // Stage p0: latch the word; the converter starts on the same edge.
  always_ff @(posedge clk) begin
    if (rst)       latch_p0 <= '0;
    else if (load) latch_p0 <= word_in;
  end

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (mag_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign busy = conv_busy;

  // A load landing on the final conversion cycle restarts the engine, so the
  // result it would have committed is dropped.
  assign commit = conv_done && !load;

  // Stage p1: display registers, updated only by a completed conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      disp_ovf <= 1'b0;
    end else if (commit) begin
      disp_bcd <= conv_bcd;
      disp_neg <= is_neg(latch_p0);
      disp_ovf <= overflow(latch_p0);
    end
  end

  // Per-digit codes: overflow beats sign, sign beats blanking.
  always_comb begin
    logic       seen;
    logic [3:0] nib;
    seen = 1'b0;
    nib  = '0;
    for (int i = 0; i < DIGITS; i++) codes[i] = DC_0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp_bcd[4*i +: 4];
      if (nib != 4'd0) seen = 1'b1;
      if (LZ_BLANK != 0 && !seen && i != 0) codes[i] = DC_BLANK;
      else                                  codes[i] = digit_code_t'(nib);
    end
    if (disp_neg) codes[DIGITS-1] = DC_MINUS;
    if (disp_ovf) begin
      for (int i = 0; i < DIGITS; i++) codes[i] = DC_ERR;
    end
  end

  // Stage p2: prescaler, digit index and registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      an  <= ~DIGITS'(1);
      seg <= SEG_0;
    end else begin
      if (pre == PRE_W'(SCAN_DIV - 1)) begin
        pre <= '0;
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        pre <= pre + PRE_W'(1);
      end
      an  <= ~(DIGITS'(1) << idx);
      seg <= seg_of(codes[idx]);
    end
  end

endmodule
